// File: rtl/disk_byte_fifo_if.sv
// ---------------------------------------------------------------------------
// disk_byte_fifo_if
// Bundles the host-side (CtrlModule) and FDC-side byte ports of
// disk_byte_fifo together with its occupancy/status outputs.
//   master : the environment (host CPU + FDC) driving strobes/data
//   slave  : the FIFO block itself
// Signals:
//   host_din/host_wr_clk  host byte + push strobe into RX
//   host_dout/host_rd_clk TX head byte + pop strobe
//   fdc_dout/fdc_rd       RX head byte + pop strobe
//   fdc_din/fdc_wr        FDC byte + push strobe into TX
//   flush                 level, holds both FIFOs empty
//   rx_count/tx_count, *_empty, *_full, overrun, underrun  status
// Optional (DISK_FIFO_STATS_EN): rx_bytes_total, tx_bytes_total.
// ---------------------------------------------------------------------------
interface disk_byte_fifo_if #(
    parameter int DEPTH_LOG2 = 9,
    parameter int WIDTH      = 8
);
    logic [WIDTH-1:0]      host_din;
    logic                  host_wr_clk;
    logic [WIDTH-1:0]      host_dout;
    logic                  host_rd_clk;
    logic [WIDTH-1:0]      fdc_dout;
    logic                  fdc_rd;
    logic [WIDTH-1:0]      fdc_din;
    logic                  fdc_wr;
    logic                  flush;
    logic [DEPTH_LOG2:0]   rx_count;
    logic [DEPTH_LOG2:0]   tx_count;
    logic                  rx_empty;
    logic                  rx_full;
    logic                  tx_empty;
    logic                  tx_full;
    logic                  overrun;
    logic                  underrun;
`ifdef DISK_FIFO_STATS_EN
    logic [15:0]           rx_bytes_total;
    logic [15:0]           tx_bytes_total;
`endif

    modport master (
        output host_din, host_wr_clk, host_rd_clk, fdc_rd, fdc_din, fdc_wr, flush,
        input  host_dout, fdc_dout, rx_count, tx_count, rx_empty, rx_full,
               tx_empty, tx_full, overrun, underrun
`ifdef DISK_FIFO_STATS_EN
        , input rx_bytes_total, tx_bytes_total
`endif
    );

    modport slave (
        input  host_din, host_wr_clk, host_rd_clk, fdc_rd, fdc_din, fdc_wr, flush,
        output host_dout, fdc_dout, rx_count, tx_count, rx_empty, rx_full,
               tx_empty, tx_full, overrun, underrun
`ifdef DISK_FIFO_STATS_EN
        , output rx_bytes_total, tx_bytes_total
`endif
    );
endinterface

// File: rtl/disk_byte_fifo.sv
// ---------------------------------------------------------------------------
// disk_byte_fifo
// Two independent byte FIFOs between the OSD control CPU and the CPC FDC:
//   RX (channel 0): host_wr_clk pushes host_din, fdc_rd pops, head on fdc_dout
//   TX (channel 1): fdc_wr pushes fdc_din, host_rd_clk pops, head on host_dout
// Strobes are same-clock levels; each rising level is one event. Heads are
// first-word-fall-through and hold their last value while a FIFO is empty.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high; clears both FIFOs and all flags
//   bus    disk_byte_fifo_if.slave (data, strobes, flush, status)
// Optional feature: define DISK_FIFO_STATS_EN to add the 16-bit wrapping
// accepted-push counters rx_bytes_total / tx_bytes_total.
// ---------------------------------------------------------------------------
module disk_byte_fifo #(
    parameter int DEPTH_LOG2 = 9,
    parameter int WIDTH      = 8
) (
    input  logic             clk,
    input  logic             reset,
    disk_byte_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int PW    = DEPTH_LOG2;

    // Channel 0 = RX, channel 1 = TX.
    logic [1:0]       push_strb;
    logic [1:0]       pop_strb;
    logic [WIDTH-1:0] din_a  [2];
    logic [WIDTH-1:0] dout_a [2];
    logic [CW-1:0]    cnt_a  [2];
    logic [1:0]       ovr_set;
    logic [1:0]       unr_set;
`ifdef DISK_FIFO_STATS_EN
    logic [15:0]      total_a [2];
`endif

    assign push_strb = {bus.fdc_wr, bus.host_wr_clk};
    assign pop_strb  = {bus.host_rd_clk, bus.fdc_rd};
    assign din_a[0]  = bus.host_din;
    assign din_a[1]  = bus.fdc_din;

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [WIDTH-1:0] mem [DEPTH];
        logic             push_prev_q, pop_prev_q;
        logic             push_evt_q, pop_evt_q;
        logic [WIDTH-1:0] din_q;
        logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
        logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
        logic [CW-1:0]    cnt_q, cnt_d;
        logic [WIDTH-1:0] dout_q;
        logic             empty, full, push_ok, pop_ok;
`ifdef DISK_FIFO_STATS_EN
        logic [15:0]      total_q;
`endif

        // Edge detect: one registered pulse per rising strobe level. Events
        // arising while flush is high are dropped here.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                push_prev_q <= 1'b0;
                pop_prev_q  <= 1'b0;
                push_evt_q  <= 1'b0;
                pop_evt_q   <= 1'b0;
            end else begin
                push_prev_q <= push_strb[c];
                pop_prev_q  <= pop_strb[c];
                push_evt_q  <= push_strb[c] & ~push_prev_q & ~bus.flush;
                pop_evt_q   <= pop_strb[c] & ~pop_prev_q & ~bus.flush;
            end
        end

        // Byte captured alongside its push event.
        always_ff @(posedge clk) begin
            din_q <= din_a[c];
        end

        always_comb begin
            empty   = (cnt_q == '0);
            full    = (cnt_q == CW'(DEPTH));
            pop_ok  = pop_evt_q && !empty;
            // A pop in the same cycle frees the slot a full FIFO needs.
            push_ok = push_evt_q && (!full || pop_evt_q);
            wr_ptr_d = wr_ptr_q + PW'(push_ok);
            rd_ptr_d = rd_ptr_q + PW'(pop_ok);
            cnt_d    = cnt_q + CW'(push_ok) - CW'(pop_ok);
        end

        assign ovr_set[c] = push_evt_q && full && !pop_evt_q;
        assign unr_set[c] = pop_evt_q && empty;

        always_ff @(posedge clk) begin
            if (push_ok && !bus.flush) begin
                mem[wr_ptr_q] <= din_q;
            end
        end

        // Pointer/count update. The head register reads the next read
        // address so it is valid in the same cycle the count changes; a byte
        // written into an otherwise empty FIFO is forwarded directly since
        // the RAM does not yet hold it.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
                dout_q   <= '0;
`ifdef DISK_FIFO_STATS_EN
                total_q  <= '0;
`endif
            end else if (bus.flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
`ifdef DISK_FIFO_STATS_EN
                total_q  <= '0;
`endif
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
`ifdef DISK_FIFO_STATS_EN
                total_q  <= total_q + 16'(push_ok);
`endif
                if (cnt_d != '0) begin
                    dout_q <= (push_ok && (wr_ptr_q == rd_ptr_d)) ? din_q : mem[rd_ptr_d];
                end
            end
        end

        assign dout_a[c] = dout_q;
        assign cnt_a[c]  = cnt_q;
`ifdef DISK_FIFO_STATS_EN
        assign total_a[c] = total_q;
`endif
    end

    logic overrun_q, underrun_q;

    // Sticky error flags shared by both FIFOs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else if (bus.flush) begin
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (|ovr_set) overrun_q  <= 1'b1;
            if (|unr_set) underrun_q <= 1'b1;
        end
    end

    assign bus.fdc_dout  = dout_a[0];
    assign bus.host_dout = dout_a[1];
    assign bus.rx_count  = cnt_a[0];
    assign bus.tx_count  = cnt_a[1];
    assign bus.rx_empty  = (cnt_a[0] == '0);
    assign bus.tx_empty  = (cnt_a[1] == '0);
    assign bus.rx_full   = (cnt_a[0] == CW'(DEPTH));
    assign bus.tx_full   = (cnt_a[1] == CW'(DEPTH));
    assign bus.overrun   = overrun_q;
    assign bus.underrun  = underrun_q;
`ifdef DISK_FIFO_STATS_EN
    assign bus.rx_bytes_total = total_a[0];
    assign bus.tx_bytes_total = total_a[1];
`endif
endmodule

// File: tb/tb_disk_byte_fifo.sv
// ---------------------------------------------------------------------------
// tb_disk_byte_fifo
// Queue-based reference model of both FIFOs compared against the DUT on every
// negative clock edge, plus directed scenarios with literal expectations.
// ---------------------------------------------------------------------------
module tb_disk_byte_fifo;
    localparam int DL = 9;
    localparam int DEPTH = 1 << DL;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    disk_byte_fifo_if #(.DEPTH_LOG2(DL), .WIDTH(8)) bus ();

    disk_byte_fifo #(.DEPTH_LOG2(DL), .WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Events: a strobe level that is high now and was low at the previous
    // clock edge; each event takes effect at the following edge.
    logic [7:0]  mq_rx[$];
    logic [7:0]  mq_tx[$];
    bit          mprev [4];
    bit          mpend [4];
    logic [7:0]  mpd   [2];
    logic [7:0]  mdout [2];
    bit          movr, munr;
    logic [15:0] mtot  [2];
    bit          s     [4];

    always @(posedge clk or posedge reset) begin
        s[0] = bus.host_wr_clk; s[1] = bus.fdc_rd; s[2] = bus.fdc_wr; s[3] = bus.host_rd_clk;
        if (reset) begin
            mq_rx.delete(); mq_tx.delete();
            for (int i = 0; i < 4; i++) begin mprev[i] = 0; mpend[i] = 0; end
            mdout[0] = 8'h00; mdout[1] = 8'h00;
            movr = 0; munr = 0; mtot[0] = 0; mtot[1] = 0;
        end else begin
            if (bus.flush) begin
                mq_rx.delete(); mq_tx.delete();
                movr = 0; munr = 0; mtot[0] = 0; mtot[1] = 0;
            end else begin
                if (mpend[1]) begin
                    if (mq_rx.size() == 0) munr = 1; else void'(mq_rx.pop_front());
                end
                if (mpend[0]) begin
                    if (mq_rx.size() == DEPTH) movr = 1;
                    else begin mq_rx.push_back(mpd[0]); mtot[0]++; end
                end
                if (mq_rx.size() > 0) mdout[0] = mq_rx[0];
                if (mpend[3]) begin
                    if (mq_tx.size() == 0) munr = 1; else void'(mq_tx.pop_front());
                end
                if (mpend[2]) begin
                    if (mq_tx.size() == DEPTH) movr = 1;
                    else begin mq_tx.push_back(mpd[1]); mtot[1]++; end
                end
                if (mq_tx.size() > 0) mdout[1] = mq_tx[0];
            end
            for (int i = 0; i < 4; i++) begin
                mpend[i] = s[i] && !mprev[i] && !bus.flush;
                mprev[i] = s[i];
            end
            mpd[0] = bus.host_din;
            mpd[1] = bus.fdc_din;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("rx_count", 32'(bus.rx_count), 32'(mq_rx.size()));
        chk("tx_count", 32'(bus.tx_count), 32'(mq_tx.size()));
        chk("rx_empty", 32'(bus.rx_empty), 32'(mq_rx.size() == 0));
        chk("tx_empty", 32'(bus.tx_empty), 32'(mq_tx.size() == 0));
        chk("rx_full",  32'(bus.rx_full),  32'(mq_rx.size() == DEPTH));
        chk("tx_full",  32'(bus.tx_full),  32'(mq_tx.size() == DEPTH));
        chk("overrun",  32'(bus.overrun),  32'(movr));
        chk("underrun", 32'(bus.underrun), 32'(munr));
        chk("fdc_dout", 32'(bus.fdc_dout), 32'(mdout[0]));
        chk("host_dout", 32'(bus.host_dout), 32'(mdout[1]));
`ifdef DISK_FIFO_STATS_EN
        chk("rx_total", 32'(bus.rx_bytes_total), 32'(mtot[0]));
        chk("tx_total", 32'(bus.tx_bytes_total), 32'(mtot[1]));
`endif
    end

    // ---------------- stimulus ----------------
    task automatic strobes(input bit rp, input bit rr, input bit tp, input bit tr);
        bus.host_wr_clk = rp; bus.fdc_rd = rr; bus.fdc_wr = tp; bus.host_rd_clk = tr;
    endtask

    // One strobe pulse; returns once its effect is visible on the outputs.
    task automatic pulse(input bit rp, input bit rr, input bit tp, input bit tr,
                         input logic [7:0] hd, input logic [7:0] fd);
        @(negedge clk);
        strobes(rp, rr, tp, tr);
        bus.host_din = hd;
        bus.fdc_din  = fd;
        @(negedge clk);
        strobes(0, 0, 0, 0);
        @(negedge clk);
    endtask

    task automatic do_flush();
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        strobes(0, 0, 0, 0);
        bus.host_din = 8'h00;
        bus.fdc_din  = 8'h00;
        bus.flush    = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);

        // Idle after reset.
        chk("idle_rx_empty", 32'(bus.rx_empty), 1);
        chk("idle_tx_empty", 32'(bus.tx_empty), 1);
        chk("idle_rx_count", 32'(bus.rx_count), 0);
        chk("idle_ovr_unr", {30'd0, bus.overrun, bus.underrun}, 0);
        chk("idle_dout", {bus.fdc_dout, bus.host_dout}, 0);

        // Fill RX with 0..255,0..255, then an extra push on full.
        for (int i = 0; i < DEPTH; i++) pulse(1, 0, 0, 0, 8'(i), 8'h00);
        chk("fill_rx_full", 32'(bus.rx_full), 1);
        chk("fill_rx_count", 32'(bus.rx_count), 512);
        chk("fill_head", 32'(bus.fdc_dout), 0);
`ifdef DISK_FIFO_STATS_EN
        chk("fill_total", 32'(bus.rx_bytes_total), 512);
`endif
        pulse(1, 0, 0, 0, 8'hAA, 8'h00);
        chk("ovr_set", 32'(bus.overrun), 1);
        chk("ovr_count", 32'(bus.rx_count), 512);
        do_flush();
        chk("flush_ovr", 32'(bus.overrun), 0);
        chk("flush_count", 32'(bus.rx_count), 0);

        // Refill and drain in order.
        for (int i = 0; i < DEPTH; i++) pulse(1, 0, 0, 0, 8'(i), 8'h00);
        for (int i = 0; i < DEPTH; i++) begin
            if (i % 64 == 0) chk("drain_order", 32'(bus.fdc_dout), 32'(i % 256));
            pulse(0, 1, 0, 0, 8'h00, 8'h00);
        end
        chk("drain_empty", 32'(bus.rx_empty), 1);
        chk("drain_hold", 32'(bus.fdc_dout), 8'hFF);

        // Pop on empty, then simultaneous push+pop on empty.
        pulse(0, 1, 0, 0, 8'h00, 8'h00);
        chk("unr_set", 32'(bus.underrun), 1);
        chk("unr_dout", 32'(bus.fdc_dout), 8'hFF);
        do_flush();
        pulse(1, 1, 0, 0, 8'h5C, 8'h00);
        chk("pp_empty_count", 32'(bus.rx_count), 1);
        chk("pp_empty_dout", 32'(bus.fdc_dout), 8'h5C);
        chk("pp_empty_unr", 32'(bus.underrun), 1);
        do_flush();

        // Full TX with simultaneous push+pop.
        for (int i = 0; i < DEPTH; i++) pulse(0, 0, 1, 0, 8'h00, 8'(i) ^ 8'h3C);
        chk("tx_full", 32'(bus.tx_full), 1);
        chk("tx_head0", 32'(bus.host_dout), 8'h3C);
        pulse(0, 0, 1, 1, 8'h00, 8'h77);
        chk("tx_pp_count", 32'(bus.tx_count), 512);
        chk("tx_pp_ovr", 32'(bus.overrun), 0);
        chk("tx_pp_head", 32'(bus.host_dout), 8'h3D);
        do_flush();

        // Random traffic: push-heavy, then pop-heavy, occasional flush.
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (n < 2000)
                strobes($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                        $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
            else
                strobes($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                        $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
            bus.host_din = 8'($urandom);
            bus.fdc_din  = 8'($urandom);
            bus.flush    = ($urandom_range(0, 399) == 0);
        end
        @(negedge clk);
        strobes(0, 0, 0, 0);
        bus.flush = 1'b0;
        do_flush();

        // Reset mid-burst; strobe still high at release gives one event.
        for (int i = 0; i < 100; i++) pulse(1, 0, 0, 0, 8'(i + 7), 8'h00);
        chk("burst_count", 32'(bus.rx_count), 100);
        @(negedge clk);
        bus.host_wr_clk = 1'b1;
        bus.host_din    = 8'hE1;
        #2 reset = 1'b1;
        #1;
        chk("rst_count", 32'(bus.rx_count), 0);
        chk("rst_empty", 32'(bus.rx_empty), 1);
`ifdef DISK_FIFO_STATS_EN
        chk("rst_total", 32'(bus.rx_bytes_total), 0);
`endif
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rel_count", 32'(bus.rx_count), 1);
        chk("rel_dout", 32'(bus.fdc_dout), 8'hE1);
        repeat (3) @(negedge clk);
        chk("rel_single", 32'(bus.rx_count), 1);
        bus.host_wr_clk = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
